br_checkpoint_queue: RTL

BR_CHECKPOINT_QUEUE -- requirements
Module: br_checkpoint_queue

---
 rtl/br_checkpoint_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/br_checkpoint_queue.sv
// Checkpoint queue for in-flight conditional branches: holds prediction state until
// execution resolves the branch, then issues PHT updates and history recovery.
module br_checkpoint_queue #(
  parameter int ENTRY_NUM       = 16,
  parameter int HIST_WIDTH      = 10,
  parameter int PHT_INDEX_WIDTH = 11,
  parameter int PHT_ENTRY_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          allocValid,
  input  logic [HIST_WIDTH-1:0]         allocHistory,
  input  logic [PHT_INDEX_WIDTH-1:0]    allocPhtIndex,
  input  logic [PHT_ENTRY_WIDTH-1:0]    allocPhtPrev,
  input  logic                          allocPredTaken,
  output logic                          allocReady,
  output logic [$clog2(ENTRY_NUM)-1:0]  allocTag,
  input  logic                          resolveValid,
  input  logic [$clog2(ENTRY_NUM)-1:0]  resolveTag,
  input  logic                          resolveTaken,
  output logic                          brResultValid,
  output logic [PHT_INDEX_WIDTH-1:0]    brResultPhtIndex,
  output logic [PHT_ENTRY_WIDTH-1:0]    brResultPhtPrevValue,
  output logic                          brResultExecTaken,
  output logic                          brResultMispred,
  output logic                          recoverBrHistory,
  output logic [HIST_WIDTH-1:0]         recoveredBrHistory,
  input  logic                          commitValid,
  output logic [$clog2(ENTRY_NUM):0]    count
);

  localparam int TAG_W = $clog2(ENTRY_NUM);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]       entValid;
  logic [ENTRY_NUM-1:0]       entResolved;
  logic [HIST_WIDTH-1:0]      entHist  [ENTRY_NUM];
  logic [PHT_INDEX_WIDTH-1:0] entIdx   [ENTRY_NUM];
  logic [PHT_ENTRY_WIDTH-1:0] entPrev  [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]       entPred;

  logic [TAG_W-1:0] headPtr;
  logic [TAG_W-1:0] tailPtr;
  logic             resolveHit;
  logic             resolveMis;
  logic             allocAcc;
  logic             commitAcc;
  logic [TAG_W-1:0] keepDist;

  // Position of an entry relative to the head; larger means younger.
  function automatic logic [TAG_W-1:0] ageOf(input logic [TAG_W-1:0] idx,
                                             input logic [TAG_W-1:0] head);
    return idx - head;
  endfunction

  always_comb begin
    resolveHit = resolveValid && entValid[resolveTag] && !entResolved[resolveTag];
    resolveMis = resolveHit && (resolveTaken != entPred[resolveTag]);
    allocReady = (count < FULL_CNT) && !resolveMis;
    allocAcc   = allocValid && allocReady;
    commitAcc  = commitValid && (count != '0) && entResolved[headPtr];
    keepDist   = ageOf(resolveTag, headPtr);
  end

  assign allocTag = tailPtr;

  // Stage p0 -> p1: queue bookkeeping and registered predictor requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr              <= '0;
      tailPtr              <= '0;
      count                <= '0;
      entValid             <= '0;
      entResolved          <= '0;
      brResultValid        <= 1'b0;
      brResultPhtIndex     <= '0;
      brResultPhtPrevValue <= '0;
      brResultExecTaken    <= 1'b0;
      brResultMispred      <= 1'b0;
      recoverBrHistory     <= 1'b0;
      recoveredBrHistory   <= '0;
    end else begin
      brResultValid    <= resolveHit;
      brResultMispred  <= resolveMis;
      recoverBrHistory <= resolveMis;
      if (resolveHit) begin
        brResultPhtIndex     <= entIdx[resolveTag];
        brResultPhtPrevValue <= entPrev[resolveTag];
        brResultExecTaken    <= resolveTaken;
        entResolved[resolveTag] <= 1'b1;
      end
      if (resolveMis)
        recoveredBrHistory <= {entHist[resolveTag][HIST_WIDTH-2:0], resolveTaken};
      if (commitAcc) begin
        headPtr               <= headPtr + TAG_W'(1);
        entValid[headPtr]     <= 1'b0;
        entResolved[headPtr]  <= 1'b0;
      end
      if (resolveMis) begin
        // Everything younger than the mispredicted branch is on the wrong path.
        for (int i = 0; i < ENTRY_NUM; i++) begin
          if (ageOf(TAG_W'(i), headPtr) > keepDist) begin
            entValid[i]    <= 1'b0;
            entResolved[i] <= 1'b0;
          end
        end
        tailPtr <= resolveTag + TAG_W'(1);
        count   <= {1'b0, keepDist} + (TAG_W+1)'(1) - (TAG_W+1)'(commitAcc);
      end else begin
        if (allocAcc) begin
          entValid[tailPtr]    <= 1'b1;
          entResolved[tailPtr] <= 1'b0;
          tailPtr              <= tailPtr + TAG_W'(1);
        end
        count <= count + (TAG_W+1)'(allocAcc) - (TAG_W+1)'(commitAcc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (allocAcc) begin
      entHist[tailPtr] <= allocHistory;
      entIdx[tailPtr]  <= allocPhtIndex;
      entPrev[tailPtr] <= allocPhtPrev;
      entPred[tailPtr] <= allocPredTaken;
    end
  end

endmodule
